// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: sequences FETCH/DECODE/EXEC/MEM/WB with req/ack
// handshakes to both memories and parks in a sticky TRAP on illegal encodings.
module multicycle_controller #(
  parameter int instr_width  = 32,
  parameter int alu_op_width = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [instr_width-1:0]  instr_rdata,
  input  logic                    imem_ack,
  input  logic                    dmem_ack,
  input  logic                    branch_taken,
  output logic                    imem_req,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [alu_op_width-1:0] alu_op,
  output logic                    alu_src_imm,
  output logic                    wb_sel,
  output logic                    regfile_write_enable,
  output logic                    pc_write,
  output logic                    pc_sel,
  output logic [instr_width-1:0]  ir,
  output logic                    illegal_instr
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [alu_op_width-1:0] ALU_ADD  = alu_op_width'(0);
  localparam logic [alu_op_width-1:0] ALU_SUB  = alu_op_width'(1);
  localparam logic [alu_op_width-1:0] ALU_SLL  = alu_op_width'(2);
  localparam logic [alu_op_width-1:0] ALU_SLT  = alu_op_width'(3);
  localparam logic [alu_op_width-1:0] ALU_SLTU = alu_op_width'(4);
  localparam logic [alu_op_width-1:0] ALU_XOR  = alu_op_width'(5);
  localparam logic [alu_op_width-1:0] ALU_SRL  = alu_op_width'(6);
  localparam logic [alu_op_width-1:0] ALU_SRA  = alu_op_width'(7);
  localparam logic [alu_op_width-1:0] ALU_OR   = alu_op_width'(8);
  localparam logic [alu_op_width-1:0] ALU_AND  = alu_op_width'(9);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  function automatic logic f_legal(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R: ok = (f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OP_I: begin
        case (f3)
          3'b001:  ok = (f7 == F7_ZERO);
          3'b101:  ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
          default: ok = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE, OP_BRANCH: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [alu_op_width-1:0] f_alu_base(input logic [2:0] f3);
    logic [alu_op_width-1:0] res;
    case (f3)
      3'b000:  res = ALU_ADD;
      3'b001:  res = ALU_SLL;
      3'b010:  res = ALU_SLT;
      3'b011:  res = ALU_SLTU;
      3'b100:  res = ALU_XOR;
      3'b101:  res = ALU_SRL;
      3'b110:  res = ALU_OR;
      default: res = ALU_AND;
    endcase
    return res;
  endfunction

  // func7[5] (alt) picks sub/sra for R-type but only srai for I-type, whose upper bits are immediate.
  function automatic logic [alu_op_width-1:0] f_alu_op(input logic [6:0] op, input logic [2:0] f3,
                                                       input logic alt);
    logic [alu_op_width-1:0] res;
    res = ALU_ADD;
    case (op)
      OP_R: begin
        if (alt && (f3 == 3'b000))      res = ALU_SUB;
        else if (alt && (f3 == 3'b101)) res = ALU_SRA;
        else                            res = f_alu_base(f3);
      end
      OP_I: begin
        if (alt && (f3 == 3'b101)) res = ALU_SRA;
        else                       res = f_alu_base(f3);
      end
      OP_BRANCH: res = ALU_SUB;
      default:   res = ALU_ADD;
    endcase
    return res;
  endfunction

  state_t                  r_state;
  state_t                  w_state_next;
  logic [instr_width-1:0]  r_ir;
  logic [instr_width-1:0]  w_ir_next;

  logic                    r_imem_req;
  logic                    r_dmem_req;
  logic                    r_dmem_we;
  logic [alu_op_width-1:0] r_alu_op;
  logic                    r_alu_src_imm;
  logic                    r_wb_sel;
  logic                    r_rf_we;
  logic                    r_pc_write;
  logic                    r_branch_exec;
  logic                    r_illegal;

  logic w_cur_legal;
  logic w_cur_load;
  logic w_cur_store;
  logic w_cur_branch;
  assign w_cur_legal  = f_legal(r_ir[6:0], r_ir[14:12], r_ir[31:25]);
  assign w_cur_load   = (r_ir[6:0] == OP_LOAD);
  assign w_cur_store  = (r_ir[6:0] == OP_STORE);
  assign w_cur_branch = (r_ir[6:0] == OP_BRANCH);

  // Decode of the instruction that will be in ir next cycle, used to register the outputs.
  logic [6:0]              w_nx_op;
  logic                    w_nx_imm;
  logic                    w_nx_load;
  logic                    w_nx_store;
  logic                    w_nx_branch;
  logic                    w_nx_rd_nz;
  logic                    w_nx_active;
  logic [alu_op_width-1:0] w_nx_alu_op;
  assign w_nx_op     = w_ir_next[6:0];
  assign w_nx_load   = (w_nx_op == OP_LOAD);
  assign w_nx_store  = (w_nx_op == OP_STORE);
  assign w_nx_branch = (w_nx_op == OP_BRANCH);
  assign w_nx_imm    = (w_nx_op == OP_I) || w_nx_load || w_nx_store;
  assign w_nx_rd_nz  = (w_ir_next[11:7] != 5'd0);
  assign w_nx_alu_op = f_alu_op(w_nx_op, w_ir_next[14:12], w_ir_next[30]);
  assign w_nx_active = (w_state_next == S_DECODE) || (w_state_next == S_EXEC) ||
                       (w_state_next == S_MEM)    || (w_state_next == S_WB);

  always_comb begin
    w_state_next = r_state;
    w_ir_next    = r_ir;
    case (r_state)
      S_FETCH: begin
        if (imem_ack) begin
          w_state_next = S_DECODE;
          w_ir_next    = instr_rdata;
        end
      end
      S_DECODE: w_state_next = w_cur_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (w_cur_branch)                    w_state_next = S_FETCH;
        else if (w_cur_load || w_cur_store)  w_state_next = S_MEM;
        else                                 w_state_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) w_state_next = w_cur_load ? S_WB : S_FETCH;
      end
      S_WB:    w_state_next = S_FETCH;
      S_TRAP:  w_state_next = S_TRAP;
      default: w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_ir          <= '0;
      r_imem_req    <= 1'b1;
      r_dmem_req    <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_alu_op      <= ALU_ADD;
      r_alu_src_imm <= 1'b0;
      r_wb_sel      <= 1'b0;
      r_rf_we       <= 1'b0;
      r_pc_write    <= 1'b0;
      r_branch_exec <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ir          <= w_ir_next;
      r_imem_req    <= (w_state_next == S_FETCH);
      r_dmem_req    <= (w_state_next == S_MEM);
      r_dmem_we     <= (w_state_next == S_MEM) && w_nx_store;
      r_alu_op      <= w_nx_active ? w_nx_alu_op : ALU_ADD;
      r_alu_src_imm <= w_nx_active && w_nx_imm;
      r_wb_sel      <= (w_state_next == S_WB) && w_nx_load;
      r_rf_we       <= (w_state_next == S_WB) && w_nx_rd_nz;
      r_pc_write    <= (w_state_next == S_WB) || ((w_state_next == S_EXEC) && w_nx_branch);
      r_branch_exec <= (w_state_next == S_EXEC) && w_nx_branch;
      r_illegal     <= (w_state_next == S_TRAP);
    end
  end

  // The comparator result and the store's completion ack must steer the PC in the same
  // cycle they arrive, otherwise the PC would move late or more than once across wait states.
  assign pc_write             = r_pc_write || ((r_state == S_MEM) && w_cur_store && dmem_ack);
  assign pc_sel               = r_branch_exec && branch_taken;
  assign imem_req             = r_imem_req;
  assign dmem_req             = r_dmem_req;
  assign dmem_we              = r_dmem_we;
  assign alu_op               = r_alu_op;
  assign alu_src_imm          = r_alu_src_imm;
  assign wb_sel               = r_wb_sel;
  assign regfile_write_enable = r_rf_we;
  assign ir                   = r_ir;
  assign illegal_instr        = r_illegal;

endmodule
